// File: rtl/vga_timing_controller.sv
// VGA raster timing generator with a one-pixel-deep output stage.
// Divides the system clock down to the pixel rate, walks the 800x525 raster,
// decodes sync/blank windows from the live counters and registers colour and
// sync together so they reach the DAC on the same pixel.
module vga_timing_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_in,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic        pix_en,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        sync_n,
  output logic        vga_clk,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Clock divider state
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             div_last;
  logic             pix_en_q;
  logic             vga_clk_q;

  // Raster counters
  logic [9:0] hcnt_q;
  logic [9:0] hcnt_d;
  logic [9:0] vcnt_q;
  logic [9:0] vcnt_d;
  logic       h_last;
  logic       v_last;

  // Decoded windows for the current counter position
  logic active;
  logic hs_raw;
  logic vs_raw;

  // Registered DAC-side outputs
  logic        frame_start_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        blank_n_q;
  logic [23:0] rgb_q;

  // Divider next state: count 0..CLK_DIV-1 and wrap
  always_comb begin
    div_last  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_last ? '0 : div_cnt_q + DIV_W'(1);
  end

  // Raster next state: hcnt wraps at the line end and carries into vcnt
  always_comb begin
    h_last = (hcnt_q == H_LAST);
    v_last = (vcnt_q == V_LAST);
    hcnt_d = h_last ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (h_last) begin
      vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  // Window decode from the live counters; registered below on pix_en
  always_comb begin
    active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_raw = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
    vs_raw = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
  end

  // Divider plus the strobes derived from it; pix_en and vga_clk both
  // follow the registered count so vga_clk rises half a pixel after the
  // output stage updates
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= div_last;
      vga_clk_q <= (div_cnt_q >= DIV_HALF);
    end
  end

  // Raster counters advance once per pixel period
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt_q <= 10'd0;
      vcnt_q <= 10'd0;
    end else if (pix_en_q) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Output stage: sync, blank and colour captured together so they stay aligned
  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= 24'd0;
    end else if (pix_en_q) begin
      hsync_q   <= hs_raw;
      vsync_q   <= vs_raw;
      blank_n_q <= active;
      rgb_q     <= active ? rgb_in : 24'd0;
    end
  end

  // Frame-start pulse on the cycle after the raster wraps to (0,0)
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_en_q && h_last && v_last;
    end
  end

  assign pixelX      = hcnt_q;
  assign pixelY      = vcnt_q;
  assign pix_en      = pix_en_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign sync_n      = 1'b0;
  assign vga_clk     = vga_clk_q;
  assign r_out       = rgb_q[23:16];
  assign g_out       = rgb_q[15:8];
  assign b_out       = rgb_q[7:0];

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
Display-side end of the pixel interface. Generates the 640x480@60 Hz raster scan (pixelX/pixelY) consumed by the pixel generator, samples the returned 24-bit RGB and drives the VGA DAC and sync pins with colour and sync pipeline-aligned. It sits between the system clock domain (50 MHz) and the board VGA connector. It also provides pixel-enable and frame-start strobes to game logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=2)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-low
rgb_in  in  24  pixel colour {R,G,B} for current pixelX/pixelY
pixelX  out  10  current horizontal count (hcnt)
pixelY  out  10  current vertical count (vcnt)
pix_en  out  1  one-clk strobe, once per pixel period
frame_start  out  1  one-clk pulse at start of each frame
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
blank_n  out  1  low outside active region
sync_n  out  1  DAC composite sync, tied 0
vga_clk  out  1  DAC pixel clock
r_out, g_out, b_out  out  8 each  DAC colour

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- Reset (rst=0 sampled on clk rising edge): div_cnt=0, hcnt=0, vcnt=0, pix_en=0, frame_start=0, hsync=1, vsync=1, blank_n=0, r/g/b_out=0. Reset mid-frame restarts the raster at (0,0) with no partial sync pulse carried over.
- Divider: div_cnt counts 0..CLK_DIV-1, wraps to 0. pix_en=1 (registered) exactly when div_cnt==CLK_DIV-1. First pix_en is CLK_DIV clks after reset release.
- Counters advance only on pix_en: hcnt+1. At hcnt==H_TOTAL-1, hcnt wraps to 0 and vcnt+1. At vcnt==V_TOTAL-1 with the hcnt wrap, vcnt wraps to 0. Counters hold when pix_en=0.
- pixelX=hcnt, pixelY=vcnt, combinational from the counters. Values >=640/480 during blanking are legal and must be tolerated downstream.
- Decode, computed from the current counters:
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs_raw low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vs_raw low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]; vsync spans whole lines.
- Output stage, registered on pix_en in the same clk the counters advance: hsync<=hs_raw, vsync<=vs_raw, blank_n<=active, {r,g,b}_out <= active ? rgb_in : 0. Latency is one pixel period; sync and colour are always aligned. rgb_in is sampled only in the pix_en cycle, so it must be stable for the pixel period.
- vga_clk=1 when div_cnt>=CLK_DIV/2, else 0 (registered from div_cnt). Its rising edge falls mid-pixel while the DAC outputs are stable. vga_clk=0 in reset.
- frame_start: registered, high for exactly one clk, the cycle after the counters wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0). Not asserted on reset release.
- sync_n is constant 0.
- No overflow paths: counters never exceed H_TOTAL-1/V_TOTAL-1. Parameters sum to <=1024 so 10 bits suffice.

Test Plan:
- Reset: hold rst=0 for 5 clks mid-frame -> all outputs at reset values. Release -> pix_en first high 2 clks later, pixelX=pixelY=0, hcnt=1 after that pix_en.
- Line timing: count pix_en between hcnt wraps = 800 (1600 clks). hsync low for exactly 96 pix_en periods, starting one pixel after hcnt=656.
- Frame timing: frame_start period = 800*525*2 = 840000 clks. vsync low for exactly 2 lines (1600 pix_en) starting one pixel after vcnt=490,hcnt=0.
- Pipeline/colour: rgb_in=24'hABCDEF at (0,0) -> next pixel r_out=8'hAB, g_out=8'hCD, b_out=8'hEF, blank_n=1.
- Blanking: rgb_in=24'hFFFFFF held constant -> outputs 0 and blank_n=0 for pixels sampled at hcnt 640..799 and vcnt 480..524; 24'hFFFFFF output at (639,479).
- vga_clk/sync_n: vga_clk toggles every clk with CLK_DIV=2, high when div_cnt=1; sync_n=0 throughout.
